// File: rtl/blink_sched_pkg.sv
// rtl/blink_sched_pkg.sv - shared types and helpers for the LED burst scheduler
package blink_sched_pkg;

    typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;

    localparam int MAX_NREQ = 8;

    function automatic int phase_len(input int cbits);
        return 1 << cbits;
    endfunction

    // First set request after 'last', wrapping modulo n; returns 'last' if none.
    function automatic int rr_pick(input logic [MAX_NREQ-1:0] r, input int last, input int n);
        int pick;
        int idx;
        pick = last;
        for (int k = n; k >= 1; k--) begin
            idx = (last + k) % n;
            if (r[idx[2:0]]) pick = idx;
        end
        return pick;
    endfunction

endpackage

// File: rtl/blink_sched_phase_timer.sv
// rtl/blink_sched_phase_timer.sv - free-running phase counter with expiry flags
module phase_timer #(
    parameter int CBITS = 13
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire,
    output logic near
);

    localparam logic [CBITS-1:0] ALL_ONES = '1;
    localparam logic [CBITS-1:0] PENULT   = ALL_ONES - CBITS'(1);

    logic [CBITS-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + CBITS'(1);
    end

    // near lets the owner register a pulse that lands on the final count
    assign expire = (cnt == ALL_ONES);
    assign near   = (cnt == PENULT);

endmodule

// File: rtl/blink_sched.sv
// rtl/blink_sched.sv - round-robin scheduler sharing one LED blinker
module blink_sched
    import blink_sched_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int CBITS      = 13,
    parameter int NBITS      = 4,
    parameter int GAP_PHASES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*NBITS-1:0]    req_cnt,
    output logic [NREQ-1:0]          grant,
    output logic [$clog2(NREQ)-1:0]  owner,
    output logic                     busy,
    output logic                     led,
    output logic [NREQ-1:0]          done
);

    localparam int OW = $clog2(NREQ);
    localparam int GW = $clog2(GAP_PHASES + 1);

    state_t               state;
    logic [NBITS-1:0]     remaining;
    logic [GW-1:0]        gap_cnt;
    logic                 expire;
    logic                 near;
    logic [MAX_NREQ-1:0]  req_ext;
    logic [OW-1:0]        pick;
    logic [NBITS-1:0]     pick_cnt;
    logic                 gap_last;

    always_comb begin
        req_ext = '0;
        req_ext[NREQ-1:0] = req;
    end

    assign pick     = OW'(rr_pick(req_ext, int'(owner), NREQ));
    assign pick_cnt = req_cnt[pick*NBITS +: NBITS];
    assign gap_last = (gap_cnt == GW'(GAP_PHASES - 1));

    // Held clear in IDLE; later phase boundaries rely on the natural wrap at expiry.
    phase_timer #(.CBITS(CBITS)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (state == IDLE),
        .en     (1'b1),
        .expire (expire),
        .near   (near)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            led       <= 1'b0;
            grant     <= '0;
            done      <= '0;
            busy      <= 1'b0;
            owner     <= OW'(NREQ - 1);
            remaining <= '0;
            gap_cnt   <= '0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        owner     <= pick;
                        remaining <= pick_cnt;
                        grant     <= NREQ'(1) << pick;
                        busy      <= 1'b1;
                        gap_cnt   <= '0;
                        if (pick_cnt != '0) begin
                            state <= ON;
                            led   <= 1'b1;
                        end else begin
                            state <= GAP;
                            led   <= 1'b0;
                        end
                    end
                end
                ON: begin
                    if (expire) begin
                        state <= OFF;
                        led   <= 1'b0;
                    end
                end
                OFF: begin
                    if (expire) begin
                        remaining <= remaining - NBITS'(1);
                        if (remaining != NBITS'(1)) begin
                            state <= ON;
                            led   <= 1'b1;
                        end else begin
                            state   <= GAP;
                            gap_cnt <= '0;
                        end
                    end
                end
                GAP: begin
                    if (near && gap_last)
                        done <= grant;
                    if (expire) begin
                        if (gap_last) begin
                            state <= IDLE;
                            grant <= '0;
                            busy  <= 1'b0;
                        end else begin
                            gap_cnt <= gap_cnt + GW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_blink_sched.sv
// tb/tb_blink_sched.sv - randomized and directed checks of blink_sched against a burst model
module tb_blink_sched;

    localparam int N     = 4;
    localparam int CB    = 2;
    localparam int NB    = 4;
    localparam int G     = 2;
    localparam int P     = 1 << CB;
    localparam int BOUND = N * (32 + G) * P;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*NB-1:0] req_cnt = '0;
    logic [N-1:0]   grant;
    logic [1:0]     owner;
    logic           busy;
    logic           led;
    logic [N-1:0]   done;

    int total = 0;
    int bad   = 0;

    blink_sched #(.NREQ(N), .CBITS(CB), .NBITS(NB), .GAP_PHASES(G)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .req_cnt (req_cnt),
        .grant   (grant),
        .owner   (owner),
        .busy    (busy),
        .led     (led),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Burst model: an active burst is described only by its count and the cycle index since grant.
    int m_busy  = 0;
    int m_owner = N - 1;
    int m_n     = 0;
    int m_k     = 0;

    function automatic int burst_len(input int n);
        return (2 * n + G) * P;
    endfunction

    function automatic int rr_next(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++)
            if (r[(last + k) % N]) return (last + k) % N;
        return last;
    endfunction

    function automatic int cnt_of(input logic [N*NB-1:0] c, input int i);
        return int'((c >> (i * NB)) & ((1 << NB) - 1));
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_busy  <= 0;
            m_owner <= N - 1;
        end else if (m_busy != 0) begin
            if (m_k == burst_len(m_n)) m_busy <= 0;
            else m_k <= m_k + 1;
        end else if (req != '0) begin
            m_owner <= rr_next(req, m_owner);
            m_n     <= cnt_of(req_cnt, rr_next(req, m_owner));
            m_k     <= 1;
            m_busy  <= 1;
        end
    end

    int pend [N];
    bit live_flag [N];

    always @(negedge clk) begin
        int e_led;
        e_led = (m_busy != 0 && m_k <= 2 * m_n * P && ((m_k - 1) / P) % 2 == 0) ? 1 : 0;
        chk("grant", int'(grant), m_busy != 0 ? (1 << m_owner) : 0);
        chk("owner", int'(owner), m_owner);
        chk("busy",  int'(busy), m_busy);
        chk("led",   int'(led), e_led);
        chk("done",  int'(done), (m_busy != 0 && m_k == burst_len(m_n)) ? (1 << m_owner) : 0);
        for (int i = 0; i < N; i++) begin
            if (done[i]) begin
                chk("liveness_bound", int'(pend[i] <= BOUND), 1);
                pend[i] = 0;
            end else if (req[i] && !rst) begin
                pend[i]++;
                if (pend[i] > BOUND && !live_flag[i]) begin
                    live_flag[i] = 1'b1;
                    chk("liveness_timeout", pend[i], BOUND);
                end
            end else begin
                pend[i] = 0;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        req = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int gcount;
        int gidx [5];
        int gcyc [5];
        int pulses;
        logic prev_led;
        logic [N-1:0] prev_grant;

        for (int i = 0; i < N; i++) begin
            pend[i] = 0;
            live_flag[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("rst_led", int'(led), 0);
        chk("rst_grant", int'(grant), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_owner", int'(owner), 3);
        rst = 1'b0;
        @(negedge clk);

        // single request, count 2
        req = 4'b0001;
        req_cnt = 16'h0002;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (c == 1) req = '0;
            chk("s1_led", int'(led), (c <= 4 || (c >= 9 && c <= 12)) ? 1 : 0);
            chk("s1_done", int'(done), c == 24 ? 1 : 0);
            chk("s1_grant", int'(grant), c <= 24 ? 1 : 0);
        end
        chk("s1_busy_end", int'(busy), 0);
        repeat (3) @(negedge clk);

        // zero count goes straight to the gap
        req = 4'b0100;
        req_cnt = 16'h0000;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 1) req = '0;
            chk("s2_led", int'(led), 0);
            chk("s2_grant", int'(grant), c <= 8 ? 4 : 0);
            chk("s2_done", int'(done), c == 8 ? 4 : 0);
        end

        // round robin with all requesters held
        do_reset();
        req = 4'b1111;
        req_cnt = 16'h1111;
        gcount = 0;
        prev_grant = '0;
        for (int c = 1; c <= 200 && gcount < 5; c++) begin
            @(negedge clk);
            if (grant != '0 && prev_grant == '0) begin
                gidx[gcount] = int'(owner);
                gcyc[gcount] = c;
                gcount++;
            end
            prev_grant = grant;
        end
        chk("rr_grants_seen", gcount, 5);
        if (gcount == 5) begin
            chk("rr_order0", gidx[0], 0);
            chk("rr_order1", gidx[1], 1);
            chk("rr_order2", gidx[2], 2);
            chk("rr_order3", gidx[3], 3);
            chk("rr_order4", gidx[4], 0);
            chk("rr_first_cycle", gcyc[0], 1);
            for (int i = 1; i < 5; i++) chk("rr_spacing", gcyc[i] - gcyc[i-1], 17);
        end
        req = '0;
        repeat (20) @(negedge clk);

        // request dropped and count changed mid-burst
        do_reset();
        req = 4'b0010;
        req_cnt = 16'h0030;
        pulses = 0;
        prev_led = 1'b0;
        for (int c = 1; c <= 33; c++) begin
            @(negedge clk);
            if (c == 6) begin
                req = '0;
                req_cnt = 16'h0010;
            end
            if (led && !prev_led) pulses++;
            prev_led = led;
            chk("s4_done", int'(done), c == 32 ? 2 : 0);
        end
        chk("s4_pulses", pulses, 3);

        // reset in the middle of a burst
        do_reset();
        req = 4'b0010;
        req_cnt = 16'h0030;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("s5_led", int'(led), 0);
        chk("s5_grant", int'(grant), 0);
        chk("s5_busy", int'(busy), 0);
        req = 4'b0011;
        req_cnt = 16'h0011;
        @(negedge clk);
        chk("s5_no_done", int'(done), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("s5_regrant", int'(grant), 1);
        req = '0;
        repeat (20) @(negedge clk);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) req = N'($urandom);
            if ($urandom_range(0, 3) == 0)
                for (int i = 0; i < N; i++) req_cnt[i*NB +: NB] = NB'($urandom_range(0, 3));
        end
        req = '0;
        repeat (40) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/blink_sched.md
Name: blink_sched

Overview:
- Round-robin scheduler sharing one LED blinker between NREQ requesters.
- Each requester asks for a burst of N blinks. The block grants the LED to one requester at a time and plays that requester's burst.
- It then inserts an inter-burst gap and signals completion.
- Sits between status sources (error, heartbeat, link) and the single board LED pin.
- Liveness is a core property: every persistently asserted request is eventually granted and completed.

Parameters:
- NREQ, 4, number of requesters (2..8).
- CBITS, 13, phase timer width; one phase lasts PHASE = 2^CBITS clk cycles.
- NBITS, 4, width of per-requester blink count.
- GAP_PHASES, 2, number of LED-off phases between bursts.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  NREQ  level request per requester.
- req_cnt  input  NREQ*NBITS  blink count per requester; slice i is bits [i*NBITS +: NBITS].
- grant  output  NREQ  one-hot current owner; all zero when idle.
- owner  output  $clog2(NREQ)  index of current/last owner.
- busy  output  1  high while a burst (including gap) is in progress.
- led  output  1  LED drive.
- done  output  NREQ  one-cycle pulse to the finished requester.

Behaviour:
- Reset is asynchronous and active-high. Reset is the only asynchronous path; all outputs are registered.
- Reset values:
  - state=IDLE, led=0, grant=0, done=0, busy=0.
  - owner=NREQ-1, so requester 0 has first priority after reset.
  - phase timer=0, remaining=0.
- States: IDLE, ON, OFF, GAP.
- IDLE:
  - If any req bit is set in cycle t, pick the first set index searching from owner+1 upward, wrapping modulo NREQ.
  - Latch owner and remaining = req_cnt[owner].
  - At t+1: grant[owner]=1 and busy=1.
  - If the count is nonzero, go to ON with led=1 at t+1.
  - If the count is 0, go directly to GAP with led=0.
- ON: led=1 for exactly PHASE cycles, then OFF.
- OFF:
  - led=0 for exactly PHASE cycles.
  - At expiry, decrement remaining.
  - If the new remaining value is nonzero, go to ON; otherwise go to GAP.
- GAP:
  - led=0 for GAP_PHASES*PHASE cycles.
  - On the last GAP cycle, done[owner]=1 for one cycle.
  - Next cycle: IDLE, grant=0, busy=0.
- Phase timer:
  - CBITS-bit up-counter, cleared on every state entry.
  - Phase expiry is when the counter reaches all ones; it wraps to 0 naturally.
  - The GAP phase count uses a separate $clog2(GAP_PHASES+1)-bit counter.
- req_cnt is sampled only at grant. Later changes to req_cnt have no effect on the current burst.
- Deasserting req mid-burst does not abort the burst. The burst completes and done still pulses.
- A requester that keeps req high after done is not re-granted ahead of other pending requesters (round-robin from owner+1).
- At most one grant bit is high at any time. grant is stable from grant cycle through the done cycle.
- No new grant is issued in the done cycle; arbitration happens only in IDLE.
  - Minimum spacing between bursts is therefore 1 IDLE cycle.
- Reset mid-burst clears everything immediately. No done pulse is generated for the aborted owner.
- Fairness bound: a continuously pending requester is granted within NREQ-1 other bursts.
- Max burst length: (2*15 + GAP_PHASES)*PHASE + 1 cycles.

Decomposition:
- Package blink_sched_pkg:
  - state enum {IDLE, ON, OFF, GAP}.
  - Function phase_len(CBITS).
  - Function rr_pick(req, last), returning the next index.
- Sub-module phase_timer:
  - CBITS counter with inputs clr and en.
  - Output expire, high when the count is all ones.
  - Instantiated once, reused by ON/OFF/GAP.
- The arbiter stays inline (single function call).

Test Plan (CBITS=2 so PHASE=4, GAP_PHASES=2, NREQ=4):
- Single request: req=0001, cnt0=2, req seen in IDLE at cycle 0.
  - grant=0001 at cycle 1; led=1 in cycles 1-4 and 9-12, led=0 in cycles 5-8 and 13-24.
  - done=0001 at cycle 24 only; busy=0 and grant=0 at cycle 25.
- Zero count: req=0100, cnt2=0 at cycle 0.
  - grant=0100 at cycle 1; led stays 0 throughout.
  - done=0100 at cycle 8; IDLE at cycle 9.
- Round-robin: req=1111 held, all cnt=1.
  - Grant order is 0,1,2,3,0.
  - Each burst lasts 2*4+8=16 cycles plus 1 IDLE cycle.
  - grant never has more than one bit set.
- Mid-burst changes: req=0010, cnt1=3; drop req and change cnt1 to 1 at cycle 6.
  - The burst still produces 3 led pulses; done=0010 at cycle 32.
- Reset mid-burst: assert rst in cycle 10 of a cnt=3 burst.
  - Immediately led=0, grant=0, busy=0; no done pulse.
  - After release, req=0001 is granted first (owner reset to 3).
- Liveness assertion: for each i, req[i] held high eventually leads to done[i]; the bench checks this with bounded timeout NREQ*(32+GAP_PHASES)*PHASE cycles.
